// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, lane/offset helpers and latency bounds for the data RAM.
package mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 16;
  localparam int CNT_W = $clog2(LAT_MAX);
  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction
  function automatic int ofs_of(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/ram_core.sv
// ram_core: unreset word array with byte-lane synchronous write and registered read port.
module ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic                       re,
  input  logic                       clr,
  input  logic [DATA_WIDTH/8-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]      w_data,
  output logic [DATA_WIDTH-1:0]      r_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DATA_WIDTH / 8; i++)
        if (be[i]) mem[idx][8*i +: 8] <= w_data[8*i +: 8];
  // the read register holds between read responses; errored accesses clear it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_data <= '0;
    else if (clr) r_data <= '0;
    else if (re) r_data <= mem[idx];
endmodule

// File: rtl/sync_data_ram.sv
// sync_data_ram: req/ready/done data memory with fixed access latency and
// misaligned / out-of-range error reporting.
module sync_data_ram
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req,
  input  logic                           w,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [lanes_of(DATA_WIDTH)-1:0] be,
  input  logic [DATA_WIDTH-1:0]          w_data,
  output logic                           ready,
  output logic                           done,
  output logic                           err,
  output logic [DATA_WIDTH-1:0]          r_data
);
  localparam int LANES = lanes_of(DATA_WIDTH);
  localparam int OFS = ofs_of(DATA_WIDTH);
  localparam int IDX = $clog2(DEPTH);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic rq_w;
  logic [ADDR_WIDTH-1:0] rq_addr;
  logic [LANES-1:0] rq_be;
  logic [DATA_WIDTH-1:0] rq_data;
  logic accept, access, bad;
  assign ready = state != WAIT;
  assign accept = req & ready;
  assign access = state == WAIT && cnt == '0;
  // decode from the latched address so bus changes during WAIT cannot leak in
  assign bad = |(rq_addr & ADDR_WIDTH'((64'd1 << OFS) - 64'd1)) | |(rq_addr >> (OFS + IDX));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
      err <= 1'b0;
      rq_w <= 1'b0;
      rq_addr <= '0;
      rq_be <= '0;
      rq_data <= '0;
    end else begin
      done <= access;
      err <= access & bad;
      if (accept) begin
        state <= WAIT;
        cnt <= CNT_W'(LATENCY - 1);
        rq_w <= w;
        rq_addr <= addr;
        rq_be <= be;
        rq_data <= w_data;
      end else if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else state <= RESP;
      end else state <= IDLE;
    end
  ram_core #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_core (
    .clk(clk),
    .rst_n(rst_n),
    .we(access & rq_w & ~bad),
    .re(access & ~rq_w & ~bad),
    .clr(access & bad),
    .be(rq_be),
    .idx(rq_addr[OFS +: IDX]),
    .w_data(rq_data),
    .r_data(r_data)
  );
endmodule

// File: tb/tb_sync_data_ram.sv
// tb_sync_data_ram: vector table, directed corner sequences and randomized traffic
// against an array model, on LATENCY=1 (index 0) and LATENCY=4 (index 1) instances.
module tb_sync_data_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2], req [2], w [2], ready [2], done [2], err [2];
  logic [31:0] addr [2], wd [2], rd [2];
  logic [3:0] be [2];
  int n_cmp = 0, n_bad = 0;
  logic [31:0] model [2][256];
  logic [31:0] held [2];
  typedef struct {logic wr; logic [31:0] a; logic [3:0] b; logic [31:0] d; logic e; logic [31:0] r;} vec_t;
  localparam int NT = 13;
  vec_t tbl [NT];
  sync_data_ram #(.LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n[0]), .req(req[0]), .w(w[0]), .addr(addr[0]),
    .be(be[0]), .w_data(wd[0]), .ready(ready[0]), .done(done[0]), .err(err[0]), .r_data(rd[0]));
  sync_data_ram #(.LATENCY(4)) u_l4 (.clk(clk), .rst_n(rst_n[1]), .req(req[1]), .w(w[1]), .addr(addr[1]),
    .be(be[1]), .w_data(wd[1]), .ready(ready[1]), .done(done[1]), .err(err[1]), .r_data(rd[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where done is seen, lat = edges from accept to access
  task automatic xact(input int k, input logic wr, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic e, output logic [31:0] r, output int lat);
    int g = 0;
    req[k] = 1'b1; w[k] = wr; addr[k] = a; be[k] = b; wd[k] = d;
    while (!ready[k] && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    req[k] = 1'b0; w[k] = 1'($urandom); addr[k] = $urandom; be[k] = 4'($urandom); wd[k] = $urandom;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!done[k] && lat < 40);
    e = err[k];
    r = rd[k];
  endtask

  task automatic run(input int k, input logic wr, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    logic e, bad;
    logic [31:0] r;
    int lat, ix;
    bad = (a % 4 != 0) || (a >= 32'd1024);
    ix = int'((a / 4) % 256);
    xact(k, wr, a, b, d, e, r, lat);
    if (bad) held[k] = 32'h0;
    else if (wr) begin
      for (int i = 0; i < 4; i++) if (b[i]) model[k][ix][8*i +: 8] = d[8*i +: 8];
    end else held[k] = model[k][ix];
    check($sformatf("lat[%0d] a=%h", k, a), lat, k == 0 ? 1 : 4);
    check($sformatf("err[%0d] a=%h", k, a), e, bad);
    check($sformatf("rdata[%0d] a=%h", k, a), r, held[k]);
  endtask

  initial begin
    logic e;
    logic [31:0] r, a;
    int lat, sel;
    int q [$];
    tbl[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h10,  4'h2, 32'h11223344, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 32'h10,  4'h0, 32'h0,        1'b0, 32'hDEAD33EF};
    tbl[4]  = '{1'b1, 32'h0,   4'hF, 32'h13579BDF, 1'b0, 32'hDEAD33EF};
    tbl[5]  = '{1'b0, 32'h12,  4'h0, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,   4'h0, 32'h0,        1'b0, 32'h13579BDF};
    tbl[8]  = '{1'b1, 32'h4,   4'hF, 32'h01020304, 1'b0, 32'h13579BDF};
    tbl[9]  = '{1'b1, 32'h4,   4'h0, 32'hAABBCCDD, 1'b0, 32'h13579BDF};
    tbl[10] = '{1'b0, 32'h4,   4'h0, 32'h0,        1'b0, 32'h01020304};
    tbl[11] = '{1'b1, 32'h3,   4'hF, 32'h55555555, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 32'hFFFFFFFC, 4'h0, 32'h0,   1'b1, 32'h0};
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b1; w[k] = 1'b1; addr[k] = 32'h10; be[k] = 4'hF; wd[k] = 32'h1; held[k] = 32'h0;
    end
    // reset held with req asserted: idle, nothing responds
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst ready[%0d]", k), ready[k], 1'b1);
      check($sformatf("rst done[%0d]", k), done[k], 1'b0);
      check($sformatf("rst err[%0d]", k), err[k], 1'b0);
      check($sformatf("rst rdata[%0d]", k), rd[k], 32'h0);
      req[k] = 1'b0;
      rst_n[k] = 1'b1;
    end
    repeat (6) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) check($sformatf("post-rst done[%0d]", k), done[k], 1'b0);
    end
    for (int t = 0; t < NT; t++) begin
      xact(0, tbl[t].wr, tbl[t].a, tbl[t].b, tbl[t].d, e, r, lat);
      check($sformatf("tbl%0d lat", t), lat, 1);
      check($sformatf("tbl%0d err", t), e, tbl[t].e);
      check($sformatf("tbl%0d rdata", t), r, tbl[t].r);
    end
    held[0] = tbl[NT-1].r;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) run(k, 1'b1, 32'(i * 4), 4'hF, $urandom);
    // held request during RESP is re-accepted: LATENCY+1 cycle period
    req[1] = 1'b1; w[1] = 1'b0; addr[1] = 32'h20; be[1] = 4'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done[1]) q.push_back(c);
    end
    req[1] = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b pulses", (q.size() >= 3), 1'b1);
    if (q.size() >= 3) begin
      check("b2b period 1", q[1] - q[0], 5);
      check("b2b period 2", q[2] - q[1], 5);
    end
    held[1] = model[1][8];
    check("b2b rdata", rd[1], held[1]);
    // reset two edges after accepting a write: aborted, memory untouched
    run(1, 1'b1, 32'h20, 4'hF, 32'h11112222);
    req[1] = 1'b1; w[1] = 1'b1; addr[1] = 32'h20; be[1] = 4'hF; wd[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort done", done[1], 1'b0);
    end
    rst_n[1] = 1'b1;
    held[1] = 32'h0;
    check("abort rdata", rd[1], 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("abort done after", done[1], 1'b0);
    end
    run(1, 1'b0, 32'h20, 4'h0, 32'h0);
    for (int k = 0; k < 2; k++)
      for (int n = 0; n < 120; n++) begin
        sel = $urandom_range(0, 9);
        a = sel == 0 ? ((32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3)))
          : sel == 1 ? ($urandom | 32'h400) & ~32'h3
          : 32'($urandom_range(0, 255)) << 2;
        run(k, 1'($urandom), a, 4'($urandom), $urandom);
      end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
